// File: rtl/i3c_ddr_pkg.sv
// Shared state encoding and CRC5 constants for the I3C HDR-DDR receive path.
package i3c_ddr_pkg;

  localparam int CRC5_WIDTH = 5;
  localparam logic [CRC5_WIDTH-1:0] CRC5_SEED = 5'h1F;
  localparam logic [CRC5_WIDTH-1:0] CRC5_POLY = 5'h05;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SHIFT,
    ST_SERIAL
  } crc_state_e;

endpackage

// File: rtl/crc5_step.sv
// One LFSR step of CRC5 (x^5+x^2+1): shift the register left and fold in a single data bit.
module crc5_step
  import i3c_ddr_pkg::*;
#(
  parameter logic [CRC5_WIDTH-1:0] POLY = CRC5_POLY
) (
  input  logic [CRC5_WIDTH-1:0] crc_in,
  input  logic                  bit_in,
  output logic [CRC5_WIDTH-1:0] crc_out
);

  logic fb;

  assign fb      = crc_in[CRC5_WIDTH-1] ^ bit_in;
  assign crc_out = {crc_in[CRC5_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/ddr_crc5.sv
// HDR-DDR CRC5 engine: accumulates CRC5 over RX bytes, then replays it MSB first on SCL edges.
// Build option: define DDR_CRC5_PARALLEL_EN for the one-byte-per-cycle fold; default is bit-serial.
module ddr_crc5
  import i3c_ddr_pkg::*;
#(
  parameter logic [CRC5_WIDTH-1:0] CRC_SEED = CRC5_SEED,
  parameter logic [CRC5_WIDTH-1:0] CRC_POLY = CRC5_POLY
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_crc_en,
  input  logic [7:0]            i_crc_data,
  input  logic                  i_crc_data_valid,
  input  logic                  i_crc_last,
  input  logic                  i_sclgen_scl_pos_edge,
  input  logic                  i_sclgen_scl_neg_edge,
  output logic                  o_crc_ready,
  output logic                  o_crc_value,
  output logic                  o_crc_valid,
  output logic [CRC5_WIDTH-1:0] o_crc_result
);

  crc_state_e            state_q, state_d;
  logic [CRC5_WIDTH-1:0] crc_q, crc_d;
  logic [CRC5_WIDTH-1:0] fold_out;
  logic [2:0]            idx_q, idx_d;
  logic                  scl_edge;
  logic                  load_result;

  // Both SCL edges carry a bit in DDR; a coincident pair still counts as one.
  assign scl_edge = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;

`ifdef DDR_CRC5_PARALLEL_EN
  for (genvar i = 0; i < 8; i++) begin : g_fold
    logic [CRC5_WIDTH-1:0] c_in;
    logic [CRC5_WIDTH-1:0] c_out;
    if (i == 0) begin : g_first
      assign c_in = crc_q;
    end else begin : g_next
      assign c_in = g_fold[i-1].c_out;
    end
    crc5_step #(.POLY(CRC_POLY)) u_step (
      .crc_in (c_in),
      .bit_in (i_crc_data[7-i]),
      .crc_out(c_out)
    );
  end
  assign fold_out = g_fold[7].c_out;
`else
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [2:0] cnt_q, cnt_d;

  crc5_step #(.POLY(CRC_POLY)) u_step (
    .crc_in (crc_q),
    .bit_in (byte_q[7]),
    .crc_out(fold_out)
  );
`endif

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    idx_d       = idx_q;
    o_crc_ready = 1'b0;
    o_crc_valid = 1'b0;
    o_crc_value = 1'b0;
`ifndef DDR_CRC5_PARALLEL_EN
    byte_d      = byte_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        o_crc_ready = i_crc_en;
        crc_d       = CRC_SEED;
        if (i_crc_en) state_d = ST_ACCUM;
      end
      ST_ACCUM: o_crc_ready = 1'b1;
`ifndef DDR_CRC5_PARALLEL_EN
      ST_SHIFT: begin
        crc_d  = fold_out;
        byte_d = {byte_q[6:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = last_q ? ST_SERIAL : ST_ACCUM;
      end
`endif
      ST_SERIAL: begin
        o_crc_valid = 1'b1;
        o_crc_value = o_crc_result[idx_q];
        if (scl_edge) begin
          idx_d = idx_q - 3'd1;
          if (idx_q == 3'd0) begin
            state_d = ST_IDLE;
            crc_d   = CRC_SEED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready is forced low while reset is held so outputs read cleared during reset.
    o_crc_ready = o_crc_ready & i_sys_rst;

    if (o_crc_ready && i_crc_data_valid) begin
`ifdef DDR_CRC5_PARALLEL_EN
      crc_d   = fold_out;
      state_d = i_crc_last ? ST_SERIAL : ST_ACCUM;
`else
      byte_d  = i_crc_data;
      last_d  = i_crc_last;
      cnt_d   = 3'd0;
      state_d = ST_SHIFT;
`endif
    end

    if (state_d == ST_SERIAL && state_q != ST_SERIAL) idx_d = 3'd4;

    if (!i_crc_en) begin
      state_d = ST_IDLE;
      crc_d   = CRC_SEED;
    end

    load_result = (state_d == ST_SERIAL) && (state_q != ST_SERIAL);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_SEED;
      idx_q        <= 3'd0;
      o_crc_result <= '0;
`ifndef DDR_CRC5_PARALLEL_EN
      byte_q       <= 8'h00;
      last_q       <= 1'b0;
      cnt_q        <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      idx_q   <= idx_d;
      if (load_result) o_crc_result <= crc_d;
`ifndef DDR_CRC5_PARALLEL_EN
      byte_q  <= byte_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr_crc5.sv
// Self-checking bench for ddr_crc5; expected CRC words are queued when a transfer is driven.
module tb_ddr_crc5;

`ifdef DDR_CRC5_PARALLEL_EN
  localparam int READY_LOW_CYCLES = 0;
  localparam int LAST_TO_VALID    = 0;
`else
  localparam int READY_LOW_CYCLES = 8;
  localparam int LAST_TO_VALID    = 8;
`endif

  logic       i_sys_clk;
  logic       i_sys_rst;
  logic       i_crc_en;
  logic [7:0] i_crc_data;
  logic       i_crc_data_valid;
  logic       i_crc_last;
  logic       i_sclgen_scl_pos_edge;
  logic       i_sclgen_scl_neg_edge;
  logic       o_crc_ready;
  logic       o_crc_value;
  logic       o_crc_valid;
  logic [4:0] o_crc_result;

  int         n_compared;
  int         n_failed;
  logic [4:0] exp_q[$];
  logic [4:0] last_result;

  ddr_crc5 dut (
    .i_sys_clk            (i_sys_clk),
    .i_sys_rst            (i_sys_rst),
    .i_crc_en             (i_crc_en),
    .i_crc_data           (i_crc_data),
    .i_crc_data_valid     (i_crc_data_valid),
    .i_crc_last           (i_crc_last),
    .i_sclgen_scl_pos_edge(i_sclgen_scl_pos_edge),
    .i_sclgen_scl_neg_edge(i_sclgen_scl_neg_edge),
    .o_crc_ready          (o_crc_ready),
    .o_crc_value          (o_crc_value),
    .o_crc_valid          (o_crc_valid),
    .o_crc_result         (o_crc_result)
  );

  initial begin
    i_sys_clk = 1'b0;
    forever #10 i_sys_clk = ~i_sys_clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bit-wise reference: MSB of each byte first, x^5+x^2+1.
  function automatic logic [4:0] model_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[4] ^ d[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic end_transfer();
    i_crc_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int waited;
    waited           = 0;
    i_crc_data       = d;
    i_crc_last       = l;
    i_crc_data_valid = 1'b1;
    #1;
    while (!o_crc_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!o_crc_ready) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL ready_timeout: ready=%b required=1 after %0d cycles", o_crc_ready, waited);
    end
    tick();
    i_crc_data_valid = 1'b0;
    i_crc_last       = 1'b0;
  endtask

  task automatic wait_valid(output logic [4:0] exp);
    int k;
    k   = 0;
    exp = 5'h00;
    while (!o_crc_valid && k < 40) begin
      tick();
      k++;
    end
    n_compared++;
    if (k !== LAST_TO_VALID) begin
      n_failed++;
      $display("[TB] FAIL valid_latency: got %0d cycles, required %0d", k, LAST_TO_VALID);
    end
    if (exp_q.size() == 0) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL scoreboard_empty: output seen with no expected result queued");
    end else begin
      exp = exp_q.pop_front();
      n_compared++;
      if (o_crc_result !== exp) begin
        n_failed++;
        $display("[TB] FAIL crc_result: got %h, required %h", o_crc_result, exp);
      end
      last_result = exp;
    end
  endtask

  task automatic shift_out(input logic [4:0] exp, input logic both_first);
    for (int b = 4; b >= 0; b--) begin
      n_compared++;
      if (o_crc_valid !== 1'b1 || o_crc_value !== exp[b]) begin
        n_failed++;
        $display("[TB] FAIL serial_bit%0d: valid=%b value=%b, required valid=1 value=%b",
                 b, o_crc_valid, o_crc_value, exp[b]);
      end
      if (both_first && b == 4) begin
        i_sclgen_scl_pos_edge = 1'b1;
        i_sclgen_scl_neg_edge = 1'b1;
      end else if (b % 2 == 0) begin
        i_sclgen_scl_pos_edge = 1'b1;
      end else begin
        i_sclgen_scl_neg_edge = 1'b1;
      end
      tick();
      i_sclgen_scl_pos_edge = 1'b0;
      i_sclgen_scl_neg_edge = 1'b0;
    end
    n_compared++;
    if (o_crc_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL valid_drop: valid=%b required 0 after fifth edge", o_crc_valid);
    end
    n_compared++;
    if (o_crc_result !== exp) begin
      n_failed++;
      $display("[TB] FAIL result_hold: got %h, required %h", o_crc_result, exp);
    end
  endtask

  task automatic test_reset();
    #2 i_sys_rst = 1'b0;
    #3;
    n_compared++;
    if (o_crc_ready !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL reset_ready: got %b, required 0", o_crc_ready);
    end
    n_compared++;
    if (o_crc_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL reset_valid: got %b, required 0", o_crc_valid);
    end
    n_compared++;
    if (o_crc_value !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL reset_value: got %b, required 0", o_crc_value);
    end
    n_compared++;
    if (o_crc_result !== 5'h00) begin
      n_failed++;
      $display("[TB] FAIL reset_result: got %h, required 00", o_crc_result);
    end
    repeat (3) @(posedge i_sys_clk);
    #1 i_sys_rst = 1'b1;
    tick();
  endtask

  task automatic test_single_byte(input logic [7:0] d, input logic [4:0] golden);
    logic [4:0] exp;
    i_crc_en = 1'b1;
    #1;
    n_compared++;
    if (o_crc_ready !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL idle_ready: got %b, required 1 with enable high", o_crc_ready);
    end
    exp_q.push_back(golden);
    send_byte(d, 1'b1);
    wait_valid(exp);
    shift_out(exp, 1'b0);
    end_transfer();
  endtask

  task automatic test_two_bytes();
    logic [4:0] exp;
    int         low;
    i_crc_en = 1'b1;
    send_byte(8'h00, 1'b0);
    low = 0;
    while (!o_crc_ready && low < 20) begin
      tick();
      low++;
    end
    n_compared++;
    if (low !== READY_LOW_CYCLES) begin
      n_failed++;
      $display("[TB] FAIL ready_low: got %0d cycles, required %0d", low, READY_LOW_CYCLES);
    end
    exp_q.push_back(model_byte(model_byte(5'h1F, 8'h00), 8'hFF));
    send_byte(8'hFF, 1'b1);
    wait_valid(exp);
    shift_out(exp, 1'b0);
    end_transfer();
  endtask

  task automatic test_en_drop();
    logic [4:0] exp;
    logic       saw_valid;
    i_crc_en = 1'b1;
    send_byte(8'hA5, 1'b0);
    i_crc_en = 1'b0;
    tick();
    n_compared++;
    if (o_crc_ready !== 1'b0 || o_crc_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL en_drop_idle: ready=%b valid=%b, required 0 0", o_crc_ready, o_crc_valid);
    end
    i_crc_en = 1'b1;
    #1;
    n_compared++;
    if (o_crc_ready !== 1'b1) begin
      n_failed++;
      $display("[TB] FAIL en_drop_reenable: ready=%b, required 1 from idle", o_crc_ready);
    end
    i_crc_en = 1'b0;
    tick();
    n_compared++;
    if (o_crc_result !== last_result) begin
      n_failed++;
      $display("[TB] FAIL en_drop_result: got %h, required %h", o_crc_result, last_result);
    end
    // Zero-byte transfer: enable pulses with no strobes.
    i_crc_en  = 1'b1;
    saw_valid = 1'b0;
    repeat (3) begin
      tick();
      if (o_crc_valid) saw_valid = 1'b1;
    end
    i_crc_en = 1'b0;
    repeat (12) begin
      tick();
      if (o_crc_valid) saw_valid = 1'b1;
    end
    n_compared++;
    if (saw_valid !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL zero_byte_valid: valid seen=%b, required 0", saw_valid);
    end
    // Partial data must not leak into the next transfer.
    i_crc_en = 1'b1;
    exp_q.push_back(5'h1B);
    send_byte(8'hFF, 1'b1);
    wait_valid(exp);
    shift_out(exp, 1'b0);
    end_transfer();
  endtask

  task automatic test_reset_serial();
    logic [4:0] exp;
    i_crc_en = 1'b1;
    exp_q.push_back(5'h0F);
    send_byte(8'h00, 1'b1);
    wait_valid(exp);
    i_sclgen_scl_pos_edge = 1'b1;
    tick();
    i_sclgen_scl_pos_edge = 1'b0;
    i_sclgen_scl_neg_edge = 1'b1;
    tick();
    i_sclgen_scl_neg_edge = 1'b0;
    n_compared++;
    if (o_crc_valid !== 1'b1 || o_crc_value !== exp[2]) begin
      n_failed++;
      $display("[TB] FAIL pre_reset_bit2: valid=%b value=%b, required 1 %b", o_crc_valid, o_crc_value, exp[2]);
    end
    i_sys_rst = 1'b0;
    #1;
    n_compared++;
    if (o_crc_valid !== 1'b0 || o_crc_value !== 1'b0 || o_crc_result !== 5'h00 || o_crc_ready !== 1'b0) begin
      n_failed++;
      $display("[TB] FAIL async_reset: valid=%b value=%b result=%h ready=%b, required 0 0 00 0",
               o_crc_valid, o_crc_value, o_crc_result, o_crc_ready);
    end
    last_result = 5'h00;
    i_crc_en = 1'b0;
    tick();
    i_sys_rst = 1'b1;
    tick();
    i_crc_en = 1'b1;
    exp_q.push_back(5'h0F);
    send_byte(8'h00, 1'b1);
    wait_valid(exp);
    shift_out(exp, 1'b0);
    end_transfer();
  endtask

  task automatic test_simultaneous_edges();
    logic [4:0] exp;
    i_crc_en = 1'b1;
    exp_q.push_back(5'h1B);
    send_byte(8'hFF, 1'b1);
    wait_valid(exp);
    shift_out(exp, 1'b1);
    end_transfer();
  endtask

  initial begin
    n_compared            = 0;
    n_failed              = 0;
    last_result           = 5'h00;
    i_sys_rst             = 1'b1;
    i_crc_en              = 1'b0;
    i_crc_data            = 8'h00;
    i_crc_data_valid      = 1'b0;
    i_crc_last            = 1'b0;
    i_sclgen_scl_pos_edge = 1'b0;
    i_sclgen_scl_neg_edge = 1'b0;

    test_reset();
    test_single_byte(8'h00, 5'h0F);
    test_single_byte(8'hFF, 5'h1B);
    test_two_bytes();
    test_en_drop();
    test_reset_serial();
    test_simultaneous_edges();

    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
